multicycle_cntrl: RTL and testbench

//  Moore FSM sequencing the multicycle MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut regs.

---
 rtl/mips_pkg.sv | 68 ++++++
 rtl/alu_cntrl.sv | 29 ++
 rtl/multicycle_cntrl.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_cntrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funcs, ALU ops, mux selects, FSM states.
// Latency: none (constants and types only).
// Backpressure: none.
package mips_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_SLT  = 5'd4;

  // Datapath mux selects
  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;
  localparam logic [1:0] REGDST_RA   = 2'b10;
  localparam logic [1:0] M2R_ALUOUT  = 2'b00;
  localparam logic [1:0] M2R_MDR     = 2'b01;
  localparam logic [1:0] M2R_PC      = 2'b10;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU   = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT= 2'b01;
  localparam logic [1:0] PCSRC_JUMP  = 2'b10;
  localparam logic [1:0] PCSRC_A     = 2'b11;

  // Control FSM states; all 16 codes of the 4-bit encoding are in use
  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BEQ    = 4'd11,
    S_BNE    = 4'd12,
    S_JUMP   = 4'd13,
    S_JAL    = 4'd14,
    S_JR     = 4'd15
  } state_e;

endpackage

// File: rtl/alu_cntrl.sv
// R-type func decode to ALU operation, with a legal flag for the supported arithmetic funcs.
// Latency: combinational.
// Backpressure: none.
module alu_cntrl
  import mips_pkg::*;
#(
  parameter int ALUOP_W  = 5,
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] func,
  output logic [ALUOP_W-1:0]  alu_operation,
  output logic                legal
);

  // Map the arithmetic func codes; jr is not an ALU op and is handled by the FSM
  always_comb begin
    alu_operation = ALU_ADD;
    legal         = 1'b1;
    case (func)
      FN_ADD:  alu_operation = ALU_ADD;
      FN_SUB:  alu_operation = ALU_SUB;
      FN_AND:  alu_operation = ALU_AND;
      FN_OR:   alu_operation = ALU_OR;
      FN_SLT:  alu_operation = ALU_SLT;
      default: legal         = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_cntrl.sv
// Moore control FSM for the multicycle MIPS datapath (shared I/D memory, IR, A/B/ALUOut).
// Latency: lw 5, sw/R/addi/slti 4, beq/bne/j/jal/jr 3 cycles from FETCH to instr_done.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready is low, one extra cycle per stalled cycle.
module multicycle_cntrl
  import mips_pkg::*;
#(
  parameter int ALUOP_W  = 5,
  parameter int OPCODE_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [OPCODE_W-1:0] func,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                branch,
  output logic                branch_ne,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic [ALUOP_W-1:0]  alu_operation,
  output logic                instr_done,
  output logic                illegal
);

  state_e state_q, state_d;

  logic [ALUOP_W-1:0] rfunc_op;
  logic               rfunc_legal;

  // The zero flag gates the PC enable inside the datapath; the FSM only raises branch/branch_ne
  logic unused_zero;
  assign unused_zero = zero;

  alu_cntrl #(
    .ALUOP_W  (ALUOP_W),
    .OPCODE_W (OPCODE_W)
  ) u_alu_cntrl (
    .func          (func),
    .alu_operation (rfunc_op),
    .legal         (rfunc_legal)
  );

  // State register; reset aborts any instruction in flight and parks in RESET
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_RESET;
    else      state_q <= state_d;
  end

  // Next state and per-state controls; every output defaults to 0 (RESET drives nothing)
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    branch        = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = REGDST_RT;
    mem_to_reg    = M2R_ALUOUT;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_src        = PCSRC_ALU;
    alu_operation = ALU_ADD;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        // PC+4 is computed alongside the instruction read and latched when it completes
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_ADDI, OP_SLTI: state_d = S_IEXEC;
          OP_BEQ:           state_d = S_BEQ;
          OP_BNE:           state_d = S_BNE;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          OP_RTYPE: begin
            if (func == FN_JR)    state_d = S_JR;
            else if (rfunc_legal) state_d = S_EXEC;
            else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        mem_to_reg = M2R_MDR;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        // The store is complete in the cycle memory accepts it
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_EXEC: begin
        alu_src_a     = 1'b1;
        alu_operation = rfunc_op;
        state_d       = S_RWB;
      end

      S_RWB: begin
        reg_dst    = REGDST_RD;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_IEXEC: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_IMM;
        alu_operation = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d       = S_IWB;
      end

      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_BEQ, S_BNE: begin
        alu_src_a     = 1'b1;
        alu_operation = ALU_SUB;
        pc_src        = PCSRC_ALUOUT;
        branch        = (state_q == S_BEQ);
        branch_ne     = (state_q == S_BNE);
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JAL: begin
        // Link writes the already-incremented PC into $31 alongside the jump
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        reg_dst    = REGDST_RA;
        mem_to_reg = M2R_PC;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JR: begin
        pc_src     = PCSRC_A;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_cntrl.sv
// Self-checking bench for multicycle_cntrl: directed cases then random instruction stream.
// Latency: n/a.
// Backpressure: random mem_ready stalls, bounded to three consecutive low cycles.
module tb_multicycle_cntrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, func;
  logic       zero, mem_ready;
  logic       pc_write, branch, branch_ne, iord, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic       reg_write, alu_src_a, instr_done, illegal;
  logic [4:0] alu_operation;

  always #5 clk = ~clk;

  multicycle_cntrl #(.ALUOP_W(5), .OPCODE_W(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_operation(alu_operation),
    .instr_done(instr_done), .illegal(illegal)
  );

  typedef struct packed {
    logic       pc_write, branch, branch_ne, iord, mem_read, mem_write, ir_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [4:0] alu_op;
    logic       instr_done, illegal;
  } ctl_t;

  // Instruction steps as named by the specification
  localparam int K_FETCH = 0, K_DECODE = 1, K_DECODE_ILL = 2, K_MEMADR = 3, K_MEMRD = 4,
                 K_MEMWB = 5, K_MEMWR = 6, K_EXEC = 7, K_RWB = 8, K_IEXEC = 9, K_IWB = 10,
                 K_BEQ = 11, K_BNE = 12, K_JUMP = 13, K_JAL = 14, K_JR = 15;
  // Instruction classes
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_JR = 3, C_ADDI = 4, C_SLTI = 5, C_BEQ = 6,
                 C_BNE = 7, C_J = 8, C_JAL = 9, C_ILL_OP = 10, C_ILL_FN = 11;

  int n_tests = 0;
  int n_fail  = 0;
  int plan[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t observed();
    ctl_t c;
    c = '{pc_write, branch, branch_ne, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
          reg_write, alu_src_a, alu_src_b, pc_src, alu_operation, instr_done, illegal};
    return c;
  endfunction

  // Expected controls of a step; go = memory completing this cycle
  function automatic ctl_t step_exp(input int k, input logic go, input logic [4:0] aop);
    ctl_t c;
    c = '0;
    case (k)
      K_FETCH:      begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = go; c.pc_write = go; end
      K_DECODE:     c.alu_src_b = 2'b11;
      K_DECODE_ILL: begin c.alu_src_b = 2'b11; c.illegal = 1; end
      K_MEMADR:     begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      K_MEMRD:      begin c.iord = 1; c.mem_read = 1; end
      K_MEMWB:      begin c.mem_to_reg = 2'b01; c.reg_write = 1; c.instr_done = 1; end
      K_MEMWR:      begin c.iord = 1; c.mem_write = 1; c.instr_done = go; end
      K_EXEC:       begin c.alu_src_a = 1; c.alu_op = aop; end
      K_RWB:        begin c.reg_dst = 2'b01; c.reg_write = 1; c.instr_done = 1; end
      K_IEXEC:      begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = aop; end
      K_IWB:        begin c.reg_write = 1; c.instr_done = 1; end
      K_BEQ:        begin c.alu_src_a = 1; c.alu_op = 5'd1; c.pc_src = 2'b01; c.branch = 1; c.instr_done = 1; end
      K_BNE:        begin c.alu_src_a = 1; c.alu_op = 5'd1; c.pc_src = 2'b01; c.branch_ne = 1; c.instr_done = 1; end
      K_JUMP:       begin c.pc_src = 2'b10; c.pc_write = 1; c.instr_done = 1; end
      K_JAL:        begin c.pc_src = 2'b10; c.pc_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
                          c.reg_write = 1; c.instr_done = 1; end
      K_JR:         begin c.pc_src = 2'b11; c.pc_write = 1; c.instr_done = 1; end
      default:      c = '0;
    endcase
    return c;
  endfunction

  function automatic int base_latency(input int cls);
    case (cls)
      C_LW:                         return 5;
      C_SW, C_R, C_ADDI, C_SLTI:    return 4;
      default:                      return 3;
    endcase
  endfunction

  task automatic build_plan(input int cls);
    plan.delete();
    plan.push_back(K_FETCH);
    if (cls == C_ILL_OP || cls == C_ILL_FN) plan.push_back(K_DECODE_ILL);
    else plan.push_back(K_DECODE);
    case (cls)
      C_LW:   begin plan.push_back(K_MEMADR); plan.push_back(K_MEMRD); plan.push_back(K_MEMWB); end
      C_SW:   begin plan.push_back(K_MEMADR); plan.push_back(K_MEMWR); end
      C_R:    begin plan.push_back(K_EXEC); plan.push_back(K_RWB); end
      C_ADDI, C_SLTI: begin plan.push_back(K_IEXEC); plan.push_back(K_IWB); end
      C_BEQ:  plan.push_back(K_BEQ);
      C_BNE:  plan.push_back(K_BNE);
      C_J:    plan.push_back(K_JUMP);
      C_JAL:  plan.push_back(K_JAL);
      C_JR:   plan.push_back(K_JR);
      default: ;
    endcase
  endtask

  // Run one instruction from FETCH; in directed mode mem_ready is 1 except stall_n cycles at stall_step
  task automatic run_instr(input string name, input int cls, input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] aop, input bit rnd, input int stall_step, input int stall_n);
    int   cyc = 0, stalls = 0, done_cyc = 0, consec = 0;
    bit   left;
    logic mr;
    ctl_t exp_c;
    build_plan(cls);
    foreach (plan[i]) begin
      bit is_mem;
      is_mem = (plan[i] == K_FETCH || plan[i] == K_MEMRD || plan[i] == K_MEMWR);
      left = 0;
      for (int w = 0; w < 8; w++) begin
        if (rnd) mr = (consec < 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
        else     mr = !(i == stall_step && w < stall_n);
        @(negedge clk);
        mem_ready = mr; opcode = op; func = fn;
        zero = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        #2;
        cyc++;
        exp_c = step_exp(plan[i], mr, aop);
        check_eq($sformatf("%s step%0d cyc%0d", name, i, cyc), 32'(observed()), 32'(exp_c));
        if (instr_done && done_cyc == 0) done_cyc = cyc;
        if (!is_mem || mr) begin
          left = 1;
          consec = 0;
          break;
        end
        stalls++;
        consec++;
      end
      if (!left) check_eq({name, " stall_bound"}, 32'd0, 32'd1);
    end
    if (cls != C_ILL_OP && cls != C_ILL_FN)
      check_eq({name, " latency"}, 32'(done_cyc), 32'(base_latency(cls) + stalls));
  endtask

  task automatic pick_instr(input int cls, output logic [5:0] op, output logic [5:0] fn, output logic [4:0] aop);
    logic [5:0] rfn [5];
    int sel;
    rfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    fn  = 6'($urandom_range(0, 63));
    aop = 5'd0;
    case (cls)
      C_LW:   op = 6'h23;
      C_SW:   op = 6'h2B;
      C_R:    begin op = 6'h00; sel = $urandom_range(0, 4); fn = rfn[sel]; aop = 5'(sel); end
      C_JR:   begin op = 6'h00; fn = 6'h08; end
      C_ADDI: op = 6'h08;
      C_SLTI: begin op = 6'h0A; aop = 5'd4; end
      C_BEQ:  op = 6'h04;
      C_BNE:  op = 6'h05;
      C_J:    op = 6'h02;
      C_JAL:  op = 6'h03;
      C_ILL_OP: begin
        op = 6'($urandom_range(0, 63));
        while (op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h23, 6'h2B})
          op = 6'($urandom_range(0, 63));
      end
      default: begin
        op = 6'h00;
        while (fn inside {6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) fn = 6'($urandom_range(0, 63));
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    logic [4:0] aop;
    int cls;
    rst = 1'b0; mem_ready = 1'b0; opcode = '0; func = '0; zero = 1'b0;

    // Reset held for three cycles: everything quiet
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      check_eq($sformatf("reset_hold%0d", i), 32'(observed()), 32'd0);
    end
    @(negedge clk); rst = 1'b1; mem_ready = 1'b1; #2;
    check_eq("reset_state", 32'(observed()), 32'd0);

    // Directed cases
    run_instr("add",  C_R,      6'h00, 6'h20, 5'd0, 0, -1, 0);
    run_instr("lw_st", C_LW,    6'h23, 6'h00, 5'd0, 0,  3, 2);
    run_instr("bne",  C_BNE,    6'h05, 6'h00, 5'd0, 0, -1, 0);
    run_instr("jal",  C_JAL,    6'h03, 6'h00, 5'd0, 0, -1, 0);
    run_instr("ill3f", C_ILL_OP, 6'h3F, 6'h00, 5'd0, 0, -1, 0);
    run_instr("jr",   C_JR,     6'h00, 6'h08, 5'd0, 0, -1, 0);
    run_instr("illfn", C_ILL_FN, 6'h00, 6'h3F, 5'd0, 0, -1, 0);

    // Reset dropped while a store waits on memory: the write request vanishes at once
    @(negedge clk); opcode = 6'h2B; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b0; #2;
    check_eq("memwr_before_rst", 32'(mem_write), 32'd1);
    #1 rst = 1'b0; #1;
    check_eq("memwr_abort", 32'(observed()), 32'd0);
    @(negedge clk); #2;
    check_eq("memwr_abort_hold", 32'(observed()), 32'd0);
    @(negedge clk); rst = 1'b1; mem_ready = 1'b1; #2;
    check_eq("rerelease_state", 32'(observed()), 32'd0);

    // Random instruction stream with random memory stalls
    for (int n = 0; n < 250; n++) begin
      cls = $urandom_range(0, 11);
      pick_instr(cls, op, fn, aop);
      run_instr($sformatf("rnd%0d_c%0d", n, cls), cls, op, fn, aop, 1, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
